// File: rtl/scan_pkg.sv
// Shared types for the scan chain controller.
//   scan_mode_t  : command encodings carried on cmd_mode
//   scan_state_t : controller FSM states
//   mode_needs_in / mode_needs_out : which streams a mode consumes/produces
package scan_pkg;

   typedef enum logic [1:0] {
      MODE_EXCHANGE = 2'b00,
      MODE_ROTATE   = 2'b01,
      MODE_LOAD     = 2'b10,
      MODE_DUMP     = 2'b11
   } scan_mode_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_LEAD  = 2'b01,
      ST_SHIFT = 2'b10,
      ST_DRAIN = 2'b11
   } scan_state_t;

   function automatic logic mode_needs_in(input scan_mode_t m);
      return (m == MODE_EXCHANGE) || (m == MODE_LOAD);
   endfunction

   function automatic logic mode_needs_out(input scan_mode_t m);
      return (m != MODE_LOAD);
   endfunction

endpackage

// File: rtl/scan_out_buf.sv
// One-deep valid/ready output register for captured scan beats.
// Ports:
//   aclk, areset        : clock, async active-high reset
//   cap_valid, cap_data : load request and data (only asserted when the slot
//                         is free or being drained this cycle)
//   out_ready           : downstream accept
//   out_valid, out_data : registered beat
module scan_out_buf #(
   parameter int W = 2
) (
   input  logic         aclk,
   input  logic         areset,
   input  logic         cap_valid,
   input  logic [W-1:0] cap_data,
   input  logic         out_ready,
   output logic         out_valid,
   output logic [W-1:0] out_data
);

   logic         valid_q, valid_d;
   logic [W-1:0] data_q, data_d;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (cap_valid) begin
         valid_d = 1'b1;
         data_d  = cap_data;
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan chain controller: shifts NUM_CHAINS chains of CHAIN_LEN flops in
// lockstep for one command, streaming bits in and/or captured bits out.
// Ports:
//   aclk, areset                     : clock, async active-high reset
//   cmd_valid/cmd_ready/cmd_mode     : command handshake
//   in_valid/in_ready/in_data        : bits shifted into the chains
//   out_valid/out_ready/out_data/out_last : bits captured from the chains
//   scan_enable, scan_ck_enable      : chain mode select and shift clock gate
//   scan_input, scan_output          : chain serial data
//   busy, done                       : status
//
// state    | meaning
// ST_IDLE  | waiting for a command, cmd_ready high
// ST_LEAD  | one setup cycle with scan_enable high, no shift
// ST_SHIFT | shifting, one bit per fire, CHAIN_LEN fires
// ST_DRAIN | waiting for the last captured beat to leave
module scan_chain_ctrl
   import scan_pkg::*;
#(
   parameter int NUM_CHAINS = 1,
   parameter int CHAIN_LEN  = 128
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [1:0]            cmd_mode,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [NUM_CHAINS-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [NUM_CHAINS-1:0] out_data,
   output logic                  out_last,
   output logic                  scan_enable,
   output logic                  scan_ck_enable,
   output logic [NUM_CHAINS-1:0] scan_input,
   input  logic [NUM_CHAINS-1:0] scan_output,
   output logic                  busy,
   output logic                  done
);

   localparam int             CW       = $clog2(CHAIN_LEN + 1);
   localparam logic [CW-1:0]  LAST_IDX = CW'(CHAIN_LEN - 1);

   scan_state_t   state_q, state_d;
   scan_mode_t    mode_q, mode_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          scan_enable_q, scan_enable_d;
   logic          done_q, done_d;

   logic need_in, need_out, fire, drain_ok, last_fire;
   logic [NUM_CHAINS:0] buf_data;

   assign need_in  = mode_needs_in(mode_q);
   assign need_out = mode_needs_out(mode_q);

   // A shift only happens when the input beat is present (if consumed) and
   // the output slot can take the captured bit (if produced).
   assign fire = (state_q == ST_SHIFT)
               && (need_in  ? in_valid : 1'b1)
               && (need_out ? (!out_valid || out_ready) : 1'b1);

   assign last_fire = fire && (cnt_q == LAST_IDX);
   assign drain_ok  = !out_valid || out_ready;

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               state_d = ST_LEAD;
               mode_d  = scan_mode_t'(cmd_mode);
               cnt_d   = '0;
            end
         end
         ST_LEAD: state_d = ST_SHIFT;
         ST_SHIFT: begin
            if (fire) begin
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == LAST_IDX) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (drain_ok) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      scan_enable_d = (state_d == ST_LEAD) || (state_d == ST_SHIFT);
      done_d        = (state_q == ST_DRAIN) && drain_ok;
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q       <= ST_IDLE;
         mode_q        <= MODE_EXCHANGE;
         cnt_q         <= '0;
         scan_enable_q <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         mode_q        <= mode_d;
         cnt_q         <= cnt_d;
         scan_enable_q <= scan_enable_d;
         done_q        <= done_d;
      end
   end

   // ROTATE feeds the outgoing bit back in so the chain ends unchanged.
   always_comb begin
      scan_input = '0;
      if (state_q == ST_SHIFT) begin
         case (mode_q)
            MODE_EXCHANGE, MODE_LOAD: scan_input = in_data;
            MODE_ROTATE:              scan_input = scan_output;
            default:                  scan_input = '0;
         endcase
      end
   end

   scan_out_buf #(.W(NUM_CHAINS + 1)) u_out_buf (
      .aclk      (aclk),
      .areset    (areset),
      .cap_valid (fire && need_out),
      .cap_data  ({last_fire, scan_output}),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (buf_data)
   );

   assign out_data       = buf_data[NUM_CHAINS-1:0];
   assign out_last       = buf_data[NUM_CHAINS];
   assign scan_enable    = scan_enable_q;
   assign scan_ck_enable = fire;
   assign in_ready       = fire && need_in;
   assign cmd_ready      = (state_q == ST_IDLE);
   assign busy           = (state_q != ST_IDLE);
   assign done           = done_q;

endmodule

// File: doc/scan_chain_ctrl.md
SCAN_CHAIN_CTRL -- requirements
Module: scan_chain_ctrl

Interface
REQ-001 SHALL have parameter NUM_CHAINS, default 1, parallel scan chains driven in lockstep (1..32).
REQ-002 SHALL have parameter CHAIN_LEN, default 128, flops per chain (>=2).
REQ-003 SHALL have port aclk  in  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port areset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports cmd_valid in 1, cmd_ready out 1, cmd_mode in 2: command handshake (00 EXCHANGE, 01 ROTATE, 10 LOAD, 11 DUMP).
REQ-006 SHALL have ports in_valid in 1, in_ready out 1, in_data in NUM_CHAINS: one bit per chain per shift.
REQ-007 SHALL have ports out_valid out 1, out_ready in 1, out_data out NUM_CHAINS, out_last out 1: captured bits.
REQ-008 SHALL have ports scan_enable out 1, scan_ck_enable out 1, scan_input out NUM_CHAINS, scan_output in NUM_CHAINS: chain control/data.
REQ-009 SHALL have ports busy out 1 (state != IDLE) and done out 1 (one-cycle pulse at command completion).

Function
REQ-010 FSM states SHALL be IDLE, LEAD, SHIFT, DRAIN; cmd_ready = (state==IDLE); command accepted on cmd_valid&&cmd_ready, mode latched.
REQ-011 IDLE->LEAD on accept; LEAD lasts exactly 1 cycle with scan_enable=1, scan_ck_enable=0; LEAD->SHIFT.
REQ-012 scan_enable SHALL be registered, 1 in LEAD/SHIFT, 0 in IDLE/DRAIN.
REQ-013 In SHIFT, fire = need_in?in_valid:1 AND need_out?(!out_valid||out_ready):1; need_in for EXCHANGE/LOAD, need_out for EXCHANGE/ROTATE/DUMP.
REQ-014 scan_ck_enable SHALL equal fire (combinational); in_ready = fire && need_in.
REQ-015 scan_input SHALL be in_data (EXCHANGE/LOAD), scan_output (ROTATE, restores chain), all-zero (DUMP); all-zero outside SHIFT.
REQ-016 On fire with need_out, out_data SHALL capture scan_output (pre-shift bit) and out_valid set; out_valid clears on out_ready without a simultaneous fire.
REQ-017 Shift counter width $clog2(CHAIN_LEN+1), cleared on accept, +1 per fire; exactly CHAIN_LEN fires per command.
REQ-018 out_last SHALL be 1 with the beat captured on fire number CHAIN_LEN, 0 otherwise.
REQ-019 After fire CHAIN_LEN: SHIFT->DRAIN; DRAIN->IDLE when out_valid==0 (or out_valid&&out_ready same cycle); done pulses on that transition.
REQ-020 LOAD SHALL never assert out_valid; its DRAIN lasts 1 cycle.
REQ-021 No fire when in_valid=0 (stall) or buffer full and out_ready=0 (backpressure); scan_enable stays 1 across stalls.
REQ-022 cmd_valid outside IDLE SHALL be ignored (no queueing).

Reset
REQ-023 areset SHALL asynchronously force IDLE, counter 0, scan_enable 0, out_valid 0, out_data 0, out_last 0, done 0, busy 0; cmd_ready 1.
REQ-024 Reset mid-command SHALL abort without done; partially shifted chain contents undefined; next command starts clean.

Structure
REQ-025 Package scan_pkg SHALL hold mode enum (scan_mode_t), state enum (scan_state_t), mode encodings.
REQ-026 Output register SHALL be sub-module scan_out_buf (1-deep valid/ready register, NUM_CHAINS+1 bits).

Verification (NUM_CHAINS=2, CHAIN_LEN=8, behavioural shift-register chain model)
REQ-027 Chain preloaded 0xA5/0x3C, DUMP, out_ready=1 -> 8 beats MSB-first reproduce 0xA5/0x3C, out_last on beat 8, chain then 0x00, done once.
REQ-028 ROTATE on 0xA5/0x3C -> same 8 beats out; chain still 0xA5/0x3C after done.
REQ-029 EXCHANGE in 0xFF/0x01 on 0x12/0x34, in_valid dropped cycles 3-5 -> scan_ck_enable low those cycles, outputs 0x12/0x34, chain 0xFF/0x01.
REQ-030 DUMP with out_ready low 4 cycles after beat 2 -> exactly 8 beats, none lost/duplicated, scan_enable held 1.
REQ-031 areset at fire 5 of LOAD -> scan_enable 0 same cycle, no done, busy 0; following ROTATE completes 8 beats.
REQ-032 cmd_valid during SHIFT -> ignored; cmd_ready 0 until IDLE.
